// File: rtl/block_deserializer.sv
// Packs a stream of WIDTH-bit words into a WORDS-word block, first word in the MSB slot.
// A block is completed by the WORDS-th word or by in_last; one block is held until the consumer takes it.
module block_deserializer #(
   parameter int WIDTH = 32,
   parameter int WORDS = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [WIDTH-1:0]             in_data,
   input  logic                         in_valid,
   input  logic                         in_last,
   output logic                         in_ready,
   output logic [WIDTH*WORDS-1:0]       out_data,
   output logic [$clog2(WORDS+1)-1:0]   out_count,
   output logic                         out_last,
   output logic                         out_valid,
   input  logic                         out_ready
);

   localparam int BW = WIDTH * WORDS;
   localparam int CW = $clog2(WORDS + 1);

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t          state_r;
   state_t          next_state_s;
   logic [BW-1:0]   asm_r;
   logic [BW-1:0]   merged_s;
   logic [CW-1:0]   count_r;
   logic            accept_s;
   logic            fire_s;
   logic            complete_s;

   // Draining the held block frees the single output stage in the same cycle
   assign out_valid  = (state_r == HOLD);
   assign in_ready   = !out_valid | out_ready;
   assign accept_s   = in_valid & in_ready;
   assign fire_s     = out_valid & out_ready;
   assign complete_s = accept_s & (in_last | (count_r == CW'(WORDS - 1)));

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= FILL;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state: a completing word always lands in HOLD, even on a drain cycle
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         FILL: begin
            if (complete_s) begin
               next_state_s = HOLD;
            end else begin
               next_state_s = FILL;
            end
         end
         HOLD: begin
            if (complete_s) begin
               next_state_s = HOLD;
            end else if (fire_s) begin
               next_state_s = FILL;
            end else begin
               next_state_s = HOLD;
            end
         end
         default: begin
            next_state_s = FILL;
         end
      endcase
   end

   // Assembly buffer with the incoming word dropped into slot count_r
   always_comb begin
      merged_s = asm_r;
      for (int k = 0; k < WORDS; k++) begin
         if (count_r == CW'(k)) begin
            merged_s[WIDTH*(WORDS-k)-1 -: WIDTH] = in_data;
         end else begin
            merged_s[WIDTH*(WORDS-k)-1 -: WIDTH] = asm_r[WIDTH*(WORDS-k)-1 -: WIDTH];
         end
      end
   end

   // Assembly and output registers; the buffer clears as a block is handed over
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         asm_r     <= '0;
         count_r   <= '0;
         out_data  <= '0;
         out_count <= '0;
         out_last  <= 1'b0;
      end else if (complete_s) begin
         out_data  <= merged_s;
         out_count <= count_r + CW'(1);
         out_last  <= in_last;
         asm_r     <= '0;
         count_r   <= '0;
      end else if (accept_s) begin
         asm_r     <= merged_s;
         count_r   <= count_r + CW'(1);
      end
   end

endmodule

// File: tb/tb_block_deserializer.sv
// Randomized and directed bench for block_deserializer, checked against a queue-based block model.
module tb_block_deserializer;

   localparam int WIDTH = 32;
   localparam int WORDS = 16;
   localparam int BW    = WIDTH * WORDS;
   localparam int CW    = $clog2(WORDS + 1);

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [WIDTH-1:0]  in_data = '0;
   logic              in_valid = 1'b0;
   logic              in_last = 1'b0;
   logic              in_ready;
   logic [BW-1:0]     out_data;
   logic [CW-1:0]     out_count;
   logic              out_last;
   logic              out_valid;
   logic              out_ready = 1'b0;

   int checks = 0;
   int failures = 0;
   int blocks_seen = 0;

   typedef struct {
      logic [BW-1:0] data;
      int            cnt;
      bit            last;
   } blk_t;

   logic [WIDTH-1:0] part_q[$];
   blk_t             pres_q[$];

   block_deserializer #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_count (out_count),
      .out_last  (out_last),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Big-endian packing: shift words in, then left-justify the block
   function automatic blk_t build_block(input bit last);
      blk_t b;
      b.data = '0;
      foreach (part_q[i]) b.data = (b.data << WIDTH) | BW'(part_q[i]);
      b.data = b.data << (WIDTH * (WORDS - part_q.size()));
      b.cnt  = part_q.size();
      b.last = last;
      return b;
   endfunction

   // Reference model: checks outputs mid-cycle and predicts the effect of the next edge
   always @(negedge clk) begin
      bit   exp_v;
      bit   exp_rdy;
      blk_t b;
      if (rst) begin
         part_q.delete();
         pres_q.delete();
      end else begin
         exp_v   = (pres_q.size() != 0);
         exp_rdy = !exp_v || out_ready;
         check("out_valid", BW'(out_valid), BW'(exp_v));
         check("in_ready", BW'(in_ready), BW'(exp_rdy));
         if (exp_v) begin
            check("out_data", out_data, pres_q[0].data);
            check("out_count", BW'(out_count), BW'(pres_q[0].cnt));
            check("out_last", BW'(out_last), BW'(pres_q[0].last));
         end
         if (exp_v && out_ready) begin
            void'(pres_q.pop_front());
            blocks_seen++;
         end
         if (in_valid && exp_rdy) begin
            part_q.push_back(in_data);
            if (in_last || part_q.size() == WORDS) begin
               b = build_block(in_last);
               pres_q.push_back(b);
               part_q.delete();
            end
         end
      end
   end

   task automatic drive(input logic [WIDTH-1:0] d, input bit v, input bit l, input bit r);
      @(posedge clk);
      #1;
      in_data   = d;
      in_valid  = v;
      in_last   = l;
      out_ready = r;
   endtask

   initial begin
      int n;
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", BW'(out_valid), BW'(0));
      check("rst_data", out_data, BW'(0));
      check("rst_count", BW'(out_count), BW'(0));
      check("rst_last", BW'(out_last), BW'(0));
      rst = 1'b0;

      // Full block, streaming
      for (int i = 0; i < WORDS; i++) drive(WIDTH'(i), 1'b1, 1'b0, 1'b1);
      drive('0, 1'b0, 1'b0, 1'b1);
      drive('0, 1'b0, 1'b0, 1'b1);

      // Short block terminated by in_last
      drive(32'hA, 1'b1, 1'b0, 1'b1);
      drive(32'hB, 1'b1, 1'b0, 1'b1);
      drive(32'hC, 1'b1, 1'b1, 1'b1);
      drive('0, 1'b0, 1'b0, 1'b1);

      // Backpressure then simultaneous drain and accept
      for (int i = 0; i < WORDS; i++) drive(32'h100 + WIDTH'(i), 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) drive($urandom, 1'b1, 1'b0, 1'b0);
      drive(32'h55, 1'b1, 1'b0, 1'b1);
      drive(32'h66, 1'b1, 1'b1, 1'b1);
      drive('0, 1'b0, 1'b0, 1'b1);
      drive('0, 1'b0, 1'b0, 1'b1);

      // Three back-to-back blocks
      n = blocks_seen;
      for (int i = 0; i < 3 * WORDS; i++) drive(WIDTH'(i), 1'b1, 1'b0, 1'b1);
      drive('0, 1'b0, 1'b0, 1'b1);
      drive('0, 1'b0, 1'b0, 1'b1);
      check("b2b_blocks", BW'(blocks_seen - n), BW'(3));

      // Asynchronous reset mid-block
      for (int i = 0; i < 7; i++) drive(32'hDEAD0000 + WIDTH'(i), 1'b1, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      #1;
      rst = 1'b1;
      #1;
      check("arst_valid", BW'(out_valid), BW'(0));
      check("arst_data", out_data, BW'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < WORDS; i++) drive(32'hBEEF0000 + WIDTH'(i), 1'b1, 1'b0, 1'b1);
      drive('0, 1'b0, 1'b0, 1'b1);

      // Single-word block
      drive(32'h12345678, 1'b1, 1'b1, 1'b1);
      drive('0, 1'b0, 1'b0, 1'b1);
      drive('0, 1'b0, 1'b0, 1'b1);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         drive($urandom, ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) < 3),
               ($urandom_range(0, 9) < 6));
      end
      for (int i = 0; i < 4; i++) drive('0, 1'b0, 1'b0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
